pipe_hazard_ctrl: RTL and testbench

Central hazard and stall controller for the 5-stage MIPS pipeline. It watches the ID/EX, EX/MEM and data-memory handshake signals. It drives the write-enable and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers, and the PC source select. It sequences three events:
- load-use bubbles
- taken-branch flushes (branch resolved in MEM)
- whole-pipeline freezes while data memory is not ready, with a timeout fault

---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      WAIT  = 2'd1,
      FAULT = 2'd2
   } hz_state_e;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_o <= '0;
      end else if (inc && (cnt_o != '1)) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use, taken-branch and memory-wait control for the 5-stage pipeline
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_writeReg_addr_i,
   input  logic [4:0]       IFID_rs_i,
   input  logic [4:0]       IFID_rt_i,
   input  logic             IFID_uses_rt_i,
   input  logic             EXMEM_Branch_i,
   input  logic             EXMEM_BeqBne_i,
   input  logic             EXMEM_zero_i,
   input  logic             EXMEM_MemRead_i,
   input  logic             EXMEM_MemWrite_i,
   input  logic             dmem_ready_i,
   output logic             PC_write_o,
   output logic             PC_src_o,
   output logic             IFID_write_o,
   output logic             IFID_flush_o,
   output logic             IDEX_write_o,
   output logic             IDEX_flush_o,
   output logic             EXMEM_write_o,
   output logic             EXMEM_flush_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

   hz_state_e  state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [7:0] wait_inc;
   logic       mem_busy, taken, lu, freeze;

   assign mem_busy = (EXMEM_MemRead_i | EXMEM_MemWrite_i) & ~dmem_ready_i;
   assign taken    = EXMEM_Branch_i & (EXMEM_zero_i ^ EXMEM_BeqBne_i);
   assign lu       = IDEX_MemRead_i & (IDEX_writeReg_addr_i != ZERO_REG) &
                     ((IDEX_writeReg_addr_i == IFID_rs_i) |
                      (IFID_uses_rt_i & (IDEX_writeReg_addr_i == IFID_rt_i)));
   assign freeze   = mem_busy | (state_q == FAULT);
   assign wait_inc = wait_cnt_q + 8'd1;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         err_o      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_o      <= err_o | (state_d == FAULT);
      end
   end

   // The RUN cycle that first sees the busy access is not a wait cycle;
   // FAULT fires on the WAIT_MAX-th busy cycle spent in WAIT.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            if (mem_busy) begin
               state_d    = WAIT;
               wait_cnt_d = '0;
            end
         end
         WAIT: begin
            if (!mem_busy) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_inc == WAIT_LIM) begin
               state_d = FAULT;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         FAULT: state_d = FAULT;
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      PC_write_o    = 1'b1;
      PC_src_o      = 1'b0;
      IFID_write_o  = 1'b1;
      IFID_flush_o  = 1'b0;
      IDEX_write_o  = 1'b1;
      IDEX_flush_o  = 1'b0;
      EXMEM_write_o = 1'b1;
      EXMEM_flush_o = 1'b0;
      if (freeze) begin
         PC_write_o    = 1'b0;
         IFID_write_o  = 1'b0;
         IDEX_write_o  = 1'b0;
         EXMEM_write_o = 1'b0;
      end else if (taken) begin
         PC_src_o      = 1'b1;
         IFID_flush_o  = 1'b1;
         IDEX_flush_o  = 1'b1;
         EXMEM_flush_o = 1'b1;
      end else if (lu) begin
         PC_write_o   = 1'b0;
         IFID_write_o = 1'b0;
         IDEX_flush_o = 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .inc   (~PC_write_o),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .inc   (taken & ~freeze),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   localparam int CW = 4;

   localparam logic [7:0] C_NONE   = 8'b1010_1010;
   localparam logic [7:0] C_FREEZE = 8'b0000_0000;
   localparam logic [7:0] C_TAKEN  = 8'b1111_1111;
   localparam logic [7:0] C_LU     = 8'b0000_1110;

   logic          clk_i = 1'b0;
   logic          rst_n = 1'b0;
   logic          IDEX_MemRead_i = 1'b0;
   logic [4:0]    IDEX_writeReg_addr_i = '0;
   logic [4:0]    IFID_rs_i = '0;
   logic [4:0]    IFID_rt_i = '0;
   logic          IFID_uses_rt_i = 1'b0;
   logic          EXMEM_Branch_i = 1'b0;
   logic          EXMEM_BeqBne_i = 1'b0;
   logic          EXMEM_zero_i = 1'b0;
   logic          EXMEM_MemRead_i = 1'b0;
   logic          EXMEM_MemWrite_i = 1'b0;
   logic          dmem_ready_i = 1'b1;
   logic          PC_write_o, PC_src_o, IFID_write_o, IFID_flush_o;
   logic          IDEX_write_o, IDEX_flush_o, EXMEM_write_o, EXMEM_flush_o;
   logic          err_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;

   int total = 0;
   int bad   = 0;

   pipe_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(CW)) dut (
      .clk_i                (clk_i),
      .rst_n                (rst_n),
      .IDEX_MemRead_i       (IDEX_MemRead_i),
      .IDEX_writeReg_addr_i (IDEX_writeReg_addr_i),
      .IFID_rs_i            (IFID_rs_i),
      .IFID_rt_i            (IFID_rt_i),
      .IFID_uses_rt_i       (IFID_uses_rt_i),
      .EXMEM_Branch_i       (EXMEM_Branch_i),
      .EXMEM_BeqBne_i       (EXMEM_BeqBne_i),
      .EXMEM_zero_i         (EXMEM_zero_i),
      .EXMEM_MemRead_i      (EXMEM_MemRead_i),
      .EXMEM_MemWrite_i     (EXMEM_MemWrite_i),
      .dmem_ready_i         (dmem_ready_i),
      .PC_write_o           (PC_write_o),
      .PC_src_o             (PC_src_o),
      .IFID_write_o         (IFID_write_o),
      .IFID_flush_o         (IFID_flush_o),
      .IDEX_write_o         (IDEX_write_o),
      .IDEX_flush_o         (IDEX_flush_o),
      .EXMEM_write_o        (EXMEM_write_o),
      .EXMEM_flush_o        (EXMEM_flush_o),
      .err_o                (err_o),
      .stall_cnt_o          (stall_cnt_o),
      .flush_cnt_o          (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] ctrl();
      return {PC_write_o, PC_src_o, IFID_write_o, IFID_flush_o,
              IDEX_write_o, IDEX_flush_o, EXMEM_write_o, EXMEM_flush_o};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      IDEX_MemRead_i = 0; IDEX_writeReg_addr_i = 0; IFID_rs_i = 0; IFID_rt_i = 0;
      IFID_uses_rt_i = 0; EXMEM_Branch_i = 0; EXMEM_BeqBne_i = 0; EXMEM_zero_i = 0;
      EXMEM_MemRead_i = 0; EXMEM_MemWrite_i = 0; dmem_ready_i = 1;
   endtask

   initial begin
      #3;
      chk("reset_ctrl", 32'(ctrl()), 32'(C_NONE));
      chk("reset_err", 32'(err_o), 0);
      chk("reset_stall", 32'(stall_cnt_o), 0);
      chk("reset_flush", 32'(flush_cnt_o), 0);
      tick();
      rst_n = 1;
      tick();

      // load-use on rs: one bubble
      IDEX_MemRead_i = 1; IDEX_writeReg_addr_i = 5'd2; IFID_rs_i = 5'd2;
      #1 chk("lu_rs_ctrl", 32'(ctrl()), 32'(C_LU));
      tick();
      clear_inputs();
      #1 chk("lu_after_ctrl", 32'(ctrl()), 32'(C_NONE));
      chk("lu_stall_cnt", 32'(stall_cnt_o), 1);

      // load into $0 never stalls
      IDEX_MemRead_i = 1; IDEX_writeReg_addr_i = 5'd0; IFID_rs_i = 5'd0;
      #1 chk("lu_zero_ctrl", 32'(ctrl()), 32'(C_NONE));

      // rt match only counts when rt is read
      IDEX_writeReg_addr_i = 5'd7; IFID_rs_i = 5'd3; IFID_rt_i = 5'd7; IFID_uses_rt_i = 0;
      #1 chk("lu_rt_unused", 32'(ctrl()), 32'(C_NONE));
      IFID_uses_rt_i = 1;
      #1 chk("lu_rt_used", 32'(ctrl()), 32'(C_LU));
      tick();
      chk("lu_rt_stall_cnt", 32'(stall_cnt_o), 2);

      // taken bne overrides a simultaneous load-use
      EXMEM_Branch_i = 1; EXMEM_BeqBne_i = 1; EXMEM_zero_i = 0;
      #1 chk("bne_taken_ctrl", 32'(ctrl()), 32'(C_TAKEN));
      tick();
      clear_inputs();
      chk("bne_flush_cnt", 32'(flush_cnt_o), 1);
      chk("bne_stall_cnt", 32'(stall_cnt_o), 2);

      EXMEM_Branch_i = 1; EXMEM_BeqBne_i = 0; EXMEM_zero_i = 0;
      #1 chk("beq_not_taken", 32'(ctrl()), 32'(C_NONE));
      EXMEM_zero_i = 1;
      #1 chk("beq_taken", 32'(ctrl()), 32'(C_TAKEN));
      EXMEM_Branch_i = 0;
      #1;

      // store waits 3 cycles, with a taken branch held behind it
      EXMEM_MemWrite_i = 1; dmem_ready_i = 0;
      EXMEM_Branch_i = 1; EXMEM_BeqBne_i = 1; EXMEM_zero_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("store_wait_ctrl", 32'(ctrl()), 32'(C_FREEZE));
         tick();
      end
      dmem_ready_i = 1;
      #1 chk("store_done_ctrl", 32'(ctrl()), 32'(C_TAKEN));
      tick();
      clear_inputs();
      #1 chk("store_resume_ctrl", 32'(ctrl()), 32'(C_NONE));
      chk("store_stall_cnt", 32'(stall_cnt_o), 5);
      chk("store_flush_cnt", 32'(flush_cnt_o), 2);

      // memory never ready: FAULT after RUN cycle plus 15 wait cycles
      EXMEM_MemRead_i = 1; dmem_ready_i = 0;
      for (int i = 0; i < 15; i++) tick();
      chk("pre_fault_err", 32'(err_o), 0);
      chk("pre_fault_ctrl", 32'(ctrl()), 32'(C_FREEZE));
      tick();
      chk("fault_err", 32'(err_o), 1);
      clear_inputs();
      #1 chk("fault_frozen_ctrl", 32'(ctrl()), 32'(C_FREEZE));
      tick();
      chk("fault_err_sticky", 32'(err_o), 1);
      chk("fault_stall_sat", 32'(stall_cnt_o), 15);

      // asynchronous reset clears everything mid-cycle
      #2 rst_n = 0;
      #1 chk("rst_err", 32'(err_o), 0);
      chk("rst_stall", 32'(stall_cnt_o), 0);
      chk("rst_flush", 32'(flush_cnt_o), 0);
      chk("rst_ctrl", 32'(ctrl()), 32'(C_NONE));
      tick();
      rst_n = 1;
      tick();
      chk("rst_run_ctrl", 32'(ctrl()), 32'(C_NONE));

      // stall counter saturation
      IDEX_MemRead_i = 1; IDEX_writeReg_addr_i = 5'd9; IFID_rs_i = 5'd9;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", 32'(stall_cnt_o), 14);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_20", 32'(stall_cnt_o), 15);
      clear_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
